// File: rtl/pcint_ctrl_b_if.sv
// I/O bus between the CPU register file and the pin-change interrupt block.
interface pcint_ctrl_b_if;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;

  modport master (output IO_Addr, iore, iowe, dbus_in, input dbus_out, out_en);
  modport slave  (input IO_Addr, iore, iowe, dbus_in, output dbus_out, out_en);
endinterface

// File: rtl/pcint_ctrl_b.sv
// Port B pin-change interrupt: 2-flop sync + edge detect, PCICR/PCMSK0/PCIFR on the I/O bus.
// Flag latency 2 cycles from the sampling edge; reads combinational, no backpressure.
module pcint_ctrl_b #(
  parameter logic [5:0] PCIFR_Address  = 6'h1B,
  parameter logic [5:0] PCICR_Address  = 6'h38,
  parameter logic [5:0] PCMSK0_Address = 6'h39
) (
  input  logic             cp2,
  input  logic             ireset,
  pcint_ctrl_b_if.slave    bus,
  input  logic [7:0]       pin_i,
  input  logic             irq_ack,
  output logic [7:0]       PCINT,
  output logic             PCIE0,
  output logic             irq_o
);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] prev;
  logic [7:0] pcmsk0;
  logic       pcie0_q;
  logic       pcif0;
  logic [1:0] settle_cnt;

  logic [7:0] chg;
  logic       settled;
  logic       set_flag;
  logic       clr_flag;
  logic       wr_pcifr;
  logic       wr_pcicr;
  logic       wr_pcmsk0;

  assign chg       = sync2 ^ prev;
  assign settled   = (settle_cnt == 2'd3);
  assign set_flag  = pcie0_q && settled && (|(chg & pcmsk0));
  assign wr_pcifr  = bus.iowe && (bus.IO_Addr == PCIFR_Address);
  assign wr_pcicr  = bus.iowe && (bus.IO_Addr == PCICR_Address);
  assign wr_pcmsk0 = bus.iowe && (bus.IO_Addr == PCMSK0_Address);
  assign clr_flag  = (wr_pcifr && bus.dbus_in[0]) || irq_ack;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync1      <= 8'h00;
      sync2      <= 8'h00;
      prev       <= 8'h00;
      settle_cnt <= 2'd0;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
      prev  <= sync2;
      if (!settled) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end

  // Set has priority so a change landing on a clear is never lost.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcif0 <= 1'b0;
    end else if (set_flag) begin
      pcif0 <= 1'b1;
    end else if (clr_flag) begin
      pcif0 <= 1'b0;
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcmsk0  <= 8'h00;
      pcie0_q <= 1'b0;
    end else begin
      if (wr_pcmsk0) begin
        pcmsk0 <= bus.dbus_in;
      end
      if (wr_pcicr) begin
        pcie0_q <= bus.dbus_in[0];
      end
    end
  end

  always_comb begin
    bus.dbus_out = 8'h00;
    bus.out_en   = 1'b0;
    if (bus.iore) begin
      if (bus.IO_Addr == PCIFR_Address) begin
        bus.out_en   = 1'b1;
        bus.dbus_out = {7'b0, pcif0};
      end else if (bus.IO_Addr == PCICR_Address) begin
        bus.out_en   = 1'b1;
        bus.dbus_out = {7'b0, pcie0_q};
      end else if (bus.IO_Addr == PCMSK0_Address) begin
        bus.out_en   = 1'b1;
        bus.dbus_out = pcmsk0;
      end
    end
  end

  assign PCINT = pcmsk0;
  assign PCIE0 = pcie0_q;
  assign irq_o = pcif0 && pcie0_q;

endmodule

// File: tb/tb_pcint_ctrl_b.sv
// Bench for pcint_ctrl_b: directed scenarios with literal expectations, then random traffic vs. a sample-history model.
module tb_pcint_ctrl_b;

  localparam logic [5:0] A_PCIFR  = 6'h1B;
  localparam logic [5:0] A_PCICR  = 6'h38;
  localparam logic [5:0] A_PCMSK0 = 6'h39;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [7:0] pin_i;
  logic       irq_ack;
  logic [7:0] pcint_o;
  logic       pcie0_o;
  logic       irq_o;

  pcint_ctrl_b_if bus ();

  pcint_ctrl_b dut (
    .cp2    (cp2),
    .ireset (ireset),
    .bus    (bus),
    .pin_i  (pin_i),
    .irq_ack(irq_ack),
    .PCINT  (pcint_o),
    .PCIE0  (pcie0_o),
    .irq_o  (irq_o)
  );

  always #5 cp2 = ~cp2;

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pin samples indexed by edge number since reset release.
  // A flag is raised at edge n when samples n-3 and n-2 differ on a masked pin,
  // the block is enabled, and at least 4 edges have passed since release.
  int         e;
  logic [7:0] smp [4];
  logic [7:0] m_msk;
  logic       m_pcie;
  logic       m_pcif;

  always @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      e      <= 0;
      m_msk  <= 8'h00;
      m_pcie <= 1'b0;
      m_pcif <= 1'b0;
      for (int i = 0; i < 4; i++) smp[i] <= 8'h00;
    end else begin
      automatic logic hit = (e >= 3) && m_pcie &&
                            (((smp[(e - 1) % 4] ^ smp[(e - 2) % 4]) & m_msk) != 8'h00);
      automatic logic clr = (bus.iowe && bus.IO_Addr == A_PCIFR && bus.dbus_in[0]) || irq_ack;
      if (hit)      m_pcif <= 1'b1;
      else if (clr) m_pcif <= 1'b0;
      if (bus.iowe && bus.IO_Addr == A_PCICR)  m_pcie <= bus.dbus_in[0];
      if (bus.iowe && bus.IO_Addr == A_PCMSK0) m_msk  <= bus.dbus_in;
      smp[(e + 1) % 4] <= pin_i;
      e <= e + 1;
    end
  end

  function automatic logic [8:0] exp_read();
    logic [8:0] r;
    r = 9'h000;
    if (bus.iore) begin
      if (bus.IO_Addr == A_PCIFR)       r = {1'b1, 7'b0, m_pcif};
      else if (bus.IO_Addr == A_PCICR)  r = {1'b1, 7'b0, m_pcie};
      else if (bus.IO_Addr == A_PCMSK0) r = {1'b1, m_msk};
    end
    return r;
  endfunction

  // Per-cycle compare, mid low phase after inputs have settled.
  initial begin
    @(negedge cp2);
    forever begin
      @(negedge cp2);
      #2;
      if (done) break;
      begin
        automatic logic [8:0] r = exp_read();
        chk("irq_o", {7'b0, irq_o}, {7'b0, m_pcif && m_pcie});
        chk("PCINT", pcint_o, m_msk);
        chk("PCIE0", {7'b0, pcie0_o}, {7'b0, m_pcie});
        chk("out_en", {7'b0, bus.out_en}, {7'b0, r[8]});
        chk("dbus_out", bus.dbus_out, r[7:0]);
      end
    end
  end

  // All tasks start and end at a negedge drive point.
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.IO_Addr = a; bus.dbus_in = d; bus.iowe = 1'b1;
    @(negedge cp2);
    bus.iowe = 1'b0;
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [7:0] exp, input string name);
    bus.IO_Addr = a; bus.iore = 1'b1;
    #1;
    chk({name, "_data"}, bus.dbus_out, exp);
    chk({name, "_oe"}, {7'b0, bus.out_en}, 8'h01);
    @(negedge cp2);
    bus.iore = 1'b0;
  endtask

  task automatic irq_chk(input logic exp, input string name);
    #1;
    chk(name, {7'b0, irq_o}, {7'b0, exp});
  endtask

  initial begin
    ireset = 1'b0; pin_i = 8'hFF; irq_ack = 1'b0;
    bus.IO_Addr = 6'h00; bus.iore = 1'b0; bus.iowe = 1'b0; bus.dbus_in = 8'h00;
    repeat (3) @(negedge cp2);
    ireset = 1'b1;
    repeat (10) @(negedge cp2);

    // Reset values with pins high across release
    irq_chk(1'b0, "rst_irq");
    rd_chk(A_PCIFR,  8'h00, "rst_pcifr");
    rd_chk(A_PCICR,  8'h00, "rst_pcicr");
    rd_chk(A_PCMSK0, 8'h00, "rst_pcmsk0");

    pin_i = 8'h00;
    repeat (5) @(negedge cp2);
    wr(A_PCMSK0, 8'h04);
    wr(A_PCICR,  8'h01);
    repeat (3) @(negedge cp2);

    // Detection latency: sampled at edge k, flag after edge k+2
    pin_i = 8'h04;
    @(negedge cp2);
    irq_chk(1'b0, "lat_k");
    @(negedge cp2);
    irq_chk(1'b0, "lat_k1");
    @(negedge cp2);
    irq_chk(1'b1, "lat_k2");
    rd_chk(A_PCIFR, 8'h01, "lat_pcifr");

    wr(A_PCIFR, 8'h01);
    irq_chk(1'b0, "clr_wr");

    // Unmasked pin must not flag
    pin_i = 8'h24;
    for (int i = 0; i < 10; i++) begin
      @(negedge cp2);
      irq_chk(1'b0, "masked");
    end

    pin_i = 8'h20;
    repeat (3) @(negedge cp2);
    irq_chk(1'b1, "retrig");
    irq_ack = 1'b1;
    @(negedge cp2);
    irq_ack = 1'b0;
    irq_chk(1'b0, "clr_ack");

    pin_i = 8'h24;
    repeat (3) @(negedge cp2);
    wr(A_PCIFR, 8'h00);
    rd_chk(A_PCIFR, 8'h01, "wr0_keep");

    // Set lands on the same edge as a clearing write
    pin_i = 8'h20;
    @(negedge cp2);
    @(negedge cp2);
    wr(A_PCIFR, 8'h01);
    rd_chk(A_PCIFR, 8'h01, "collide");
    wr(A_PCIFR, 8'h01);
    rd_chk(A_PCIFR, 8'h00, "after_collide");

    // Pulse inside the low phase straddles no rising edge
    #1 pin_i = 8'h24;
    #2 pin_i = 8'h20;
    repeat (5) @(negedge cp2);
    irq_chk(1'b0, "narrow_pulse");

    // Enable gating
    pin_i = 8'h24;
    repeat (3) @(negedge cp2);
    irq_chk(1'b1, "gate_pre");
    wr(A_PCICR, 8'h00);
    irq_chk(1'b0, "gate_off");
    rd_chk(A_PCIFR, 8'h01, "gate_flag_kept");
    wr(A_PCICR, 8'h01);
    irq_chk(1'b1, "gate_on");

    // Asynchronous reset between edges
    #2 ireset = 1'b0;
    #1;
    chk("midrst_irq", {7'b0, irq_o}, 8'h00);
    chk("midrst_pcint", pcint_o, 8'h00);
    @(negedge cp2);
    rd_chk(A_PCIFR,  8'h00, "midrst_pcifr");
    rd_chk(A_PCICR,  8'h00, "midrst_pcicr");
    rd_chk(A_PCMSK0, 8'h00, "midrst_pcmsk0");

    // Release with pin 2 held high and detection armed immediately: no spurious flag
    ireset = 1'b1;
    wr(A_PCMSK0, 8'hFF);
    wr(A_PCICR,  8'h01);
    repeat (5) @(negedge cp2);
    irq_chk(1'b0, "settle");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      automatic int op = $urandom_range(0, 9);
      bus.iowe = 1'b0; bus.iore = 1'b0; irq_ack = 1'b0;
      if ($urandom_range(0, 3) == 0) pin_i = pin_i ^ (8'h01 << $urandom_range(0, 7));
      if (op == 0) begin
        automatic int s = $urandom_range(0, 3);
        bus.IO_Addr = (s == 0) ? A_PCIFR : (s == 1) ? A_PCICR : (s == 2) ? A_PCMSK0 : 6'($urandom);
        bus.dbus_in = 8'($urandom);
        if (s == 1 && $urandom_range(0, 3) != 0) bus.dbus_in[0] = 1'b1;
        bus.iowe = 1'b1;
      end else if (op <= 4) begin
        automatic int s = $urandom_range(0, 3);
        bus.IO_Addr = (s == 0) ? A_PCIFR : (s == 1) ? A_PCICR : (s == 2) ? A_PCMSK0 : 6'($urandom);
        bus.iore = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) irq_ack = 1'b1;
      @(negedge cp2);
    end
    bus.iowe = 1'b0; bus.iore = 1'b0; irq_ack = 1'b0;
    @(negedge cp2);
    done = 1'b1;
    #3;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pcint_ctrl_b.md
# pcint_ctrl_b

Pin-change interrupt controller for the Port B group (PCINT[7:0]): the input-side counterpart of the Port B GPIO block. It synchronises the eight raw Port B pin levels, detects level changes on enabled pins, and maintains the PCICR, PCMSK0 and PCIFR registers on the I/O bus. It drives the PCINT mask and PCIE0 enable back into Port B's digital-input-enable override logic, and raises a level interrupt request to the interrupt controller.

## Interface
Parameters:
- PCIFR_Address, 6'h1B, I/O address of PCIFR (bit 0 = PCIF0).
- PCICR_Address, 6'h38, I/O address of PCICR (bit 0 = PCIE0).
- PCMSK0_Address, 6'h39, I/O address of PCMSK0 (8-bit mask).

Ports:
- cp2  in  1  clock, all state on rising edge.
- ireset  in  1  reset, asynchronous, active-low.
- IO_Addr  in  6  I/O address.
- iore  in  1  I/O read strobe.
- iowe  in  1  I/O write strobe.
- dbus_in  in  8  write data.
- dbus_out  out  8  read data.
- out_en  out  1  high when a read hits one of this block's addresses.
- pin_i  in  8  raw Port B pin levels (Port B DIB_o).
- irq_ack  in  1  one-cycle acknowledge from the interrupt controller for vector PCINT0.
- PCINT  out  8  current PCMSK0 value, to Port B.
- PCIE0  out  1  current PCICR[0], to Port B.
- irq_o  out  1  interrupt request, PCIF0 && PCIE0.

## Operation
- **Reset (ireset=0, asynchronous):** sync1, sync2, prev, PCMSK0, PCIE0, PCIF0 all 0. The settle counter is 0, and irq_o, PCINT, PCIE0, dbus_out and out_en are all 0. Reset mid-operation drops a pending request immediately.
- **Synchroniser:** sync1 <= pin_i; sync2 <= sync1; prev <= sync2. The change vector is chg = sync2 ^ prev.
- **Settle counter:** 2-bit, saturates at 3 and counts from reset release. Change detection is suppressed while the counter is below 3, so there is no spurious flag from pins high at reset.
- **Detection:** set = PCIE0 && settled && |(chg & PCMSK0). The mask and enable values used are the register values before the current edge.
- **Flag register PCIF0:**
  - Set by `set`.
  - Cleared by an I/O write to PCIFR_Address with dbus_in[0]=1. A write of 0 has no effect.
  - Cleared by irq_ack=1.
  - If set and clear occur in the same cycle, set wins and PCIF0 stays 1.
- **Enable:** clearing PCIE0 deasserts irq_o but retains PCIF0. Re-enabling re-asserts irq_o if PCIF0 is still 1.
- **Writes (iowe && address hit):**
  - PCICR: only bit 0 is stored.
  - PCMSK0: all 8 bits are stored.
  - Writes take effect at the same edge.
- **Reads (iore && address hit):**
  - out_en=1.
  - dbus_out returns the register value, with unused bits reading 0.
  - With no hit: out_en=0 and dbus_out=8'h00.
- **Multiple changes:** several changes before the flag is cleared produce a single flag. There is no counting.

## Timing
- Pin change sampled into sync1 at edge k: chg is visible after edge k+1, and PCIF0/irq_o are high after edge k+2. Latency is 2 cycles from the sampling edge.
- A pulse narrower than one cp2 period that straddles no edge is not detected. A pulse covering exactly one sampling edge yields two changes and one flag.
- Flag clear by write or ack: PCIF0/irq_o are low after that edge, unless a coincident set occurs.
- First detectable change: the sync chain must be loaded at edges 1 and 2 after reset release, and the counter reaches 3 at edge 3.
- irq_o is combinational from registers and is glitch-free relative to cp2.
- Read data is combinational from IO_Addr/iore and is valid in the same cycle.

## Test plan
- **Reset values:** hold ireset=0 with pin_i=8'hFF, then release. After 10 cycles, expect PCIF0=0, irq_o=0, and PCMSK0/PCICR/PCIFR all reading 8'h00.
- **Basic detection latency:** write PCMSK0=8'h04 and PCICR=8'h01, then toggle pin_i[2] 0->1. Expect irq_o=1 exactly 2 cycles after the sampling edge, and a PCIFR read returning 8'h01.
- **Masked pin ignored:** with PCMSK0=8'h04, toggle pin_i[5]. Expect irq_o to stay 0 for 10 cycles.
- **Flag clear by write and by ack:**
  - Write PCIFR=8'h01: expect irq_o=0 on the next cycle.
  - Re-trigger, then pulse irq_ack: expect irq_o=0.
  - Write PCIFR=8'h00 while the flag is set: expect the flag to remain 1.
- **Set/clear collision:** time a pin_i[2] toggle so the set lands on the same edge as a PCIFR write of 1. Expect PCIF0=1 after that edge.
- **Enable gating and reset mid-operation:**
  - With a flag pending, write PCICR=0: expect irq_o=0 while PCIFR still reads 8'h01.
  - Write PCICR=1: expect irq_o=1.
  - Assert ireset between clock edges: expect irq_o=0 immediately, and all registers reading 8'h00.
